// File: rtl/rra_sequencer_pkg.sv
// Shared types and constants for the register-array micro-sequencer.
// The flag bit order matches the datapath's FR register.
package rra_sequencer_pkg;

  localparam int unsigned INSTR_W    = 20;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FLAG_W     = 4;

  // Instruction word field positions
  localparam int unsigned WR_POS     = 19;
  localparam int unsigned ALU_OP_LSB = 15;
  localparam int unsigned RD_LSB     = 10;
  localparam int unsigned RB_LSB     = 5;
  localparam int unsigned RA_LSB     = 0;

  // Flag bit indices within fr / last_flags
  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_SF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RR   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] ra;
  } instr_t;

endpackage

// File: rtl/rra_sequencer_if.sv
// Instruction handshake and datapath control bundle of the sequencer.
// master = sequencer side, slave = instruction source / datapath side.
interface rra_sequencer_if
  import rra_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic                  instr_valid;
  logic                  instr_ready;
  logic [INSTR_W-1:0]    instr;
  logic                  step;
  logic [FLAG_W-1:0]     fr;

  logic [REG_ADDR_W-1:0] r_addr_a;
  logic [REG_ADDR_W-1:0] r_addr_b;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [ALU_OP_W-1:0]   alu_op;
  logic                  rr_en;
  logic                  f_en;
  logic                  wb_en;
  logic                  reg_write;
  logic [FLAG_W-1:0]     last_flags;
  logic                  busy;
  logic [CNT_W-1:0]      op_count;

  modport master (
    input  instr_valid, instr, step, fr,
    output instr_ready, r_addr_a, r_addr_b, w_addr, alu_op,
           rr_en, f_en, wb_en, reg_write, last_flags, busy, op_count
  );

  modport slave (
    output instr_valid, instr, step, fr,
    input  instr_ready, r_addr_a, r_addr_b, w_addr, alu_op,
           rr_en, f_en, wb_en, reg_write, last_flags, busy, op_count
  );

endinterface

// File: rtl/rra_sequencer_instr_decode.sv
// Combinational split of a 20-bit instruction word into its fields.
module rra_instr_decode
  import rra_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output instr_t             fields_c
);

  always_comb begin
    fields_c.wr     = instr[WR_POS];
    fields_c.alu_op = instr[ALU_OP_LSB +: ALU_OP_W];
    fields_c.rd     = instr[RD_LSB +: REG_ADDR_W];
    fields_c.rb     = instr[RB_LSB +: REG_ADDR_W];
    fields_c.ra     = instr[RA_LSB +: REG_ADDR_W];
  end

endmodule

// File: rtl/rra_sequencer.sv
// Register-read / execute / write-back phase sequencer for the register-array datapath.
// Optional RRA_STEP_EN: RR/EX/WB phases advance only on the synchronized step pulse.
module rra_sequencer
  import rra_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  rra_sequencer_if.master bus
);

  instr_t               dec_c;

  state_e               state_q, state_d;
  instr_t               fields_q, fields_d;
  logic [FLAG_W-1:0]    last_flags_q, last_flags_d;
  logic [CNT_W-1:0]     op_count_q, op_count_d;
  logic                 busy_q, busy_d;

  logic                 step_ok_c;
  logic                 instr_ready_c;
  logic                 rr_en_c;
  logic                 f_en_c;
  logic                 wb_en_c;

  rra_instr_decode u_decode (
    .instr    (bus.instr),
    .fields_c (dec_c)
  );

`ifdef RRA_STEP_EN
  assign step_ok_c = bus.step;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign step_ok_c   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fields_q     <= '0;
      last_flags_q <= '0;
      op_count_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fields_q     <= fields_d;
      last_flags_q <= last_flags_d;
      op_count_q   <= op_count_d;
      busy_q       <= busy_d;
    end
  end

  // Each busy state fires its strobe for one advancing cycle; WB can accept the next op.
  always_comb begin
    state_d       = state_q;
    fields_d      = fields_q;
    last_flags_d  = last_flags_q;
    op_count_d    = op_count_q;
    instr_ready_c = 1'b0;
    rr_en_c       = 1'b0;
    f_en_c        = 1'b0;
    wb_en_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        instr_ready_c = 1'b1;
        if (bus.instr_valid) begin
          fields_d = dec_c;
          state_d  = ST_RR;
        end
      end
      ST_RR: begin
        if (step_ok_c) begin
          rr_en_c = 1'b1;
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (step_ok_c) begin
          f_en_c  = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (step_ok_c) begin
          wb_en_c       = 1'b1;
          instr_ready_c = 1'b1;
          last_flags_d  = bus.fr;
          op_count_d    = op_count_q + CNT_W'(1);
          if (bus.instr_valid) begin
            fields_d = dec_c;
            state_d  = ST_RR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.instr_ready = instr_ready_c;
  assign bus.rr_en       = rr_en_c;
  assign bus.f_en        = f_en_c;
  assign bus.wb_en       = wb_en_c;
  assign bus.reg_write   = wb_en_c & fields_q.wr;
  assign bus.r_addr_a    = fields_q.ra;
  assign bus.r_addr_b    = fields_q.rb;
  assign bus.w_addr      = fields_q.rd;
  assign bus.alu_op      = fields_q.alu_op;
  assign bus.last_flags  = last_flags_q;
  assign bus.busy        = busy_q;
  assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_rra_sequencer.sv
// Directed scoreboard bench for rra_sequencer (built with a 4-bit op counter to reach wrap quickly).
module tb_rra_sequencer;

  localparam int unsigned TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rra_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  rra_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                  total = 0;
  int                  bad   = 0;
  logic [19:0]         sb[$];
  logic [TB_CNT_W-1:0] m_count;
  logic [3:0]          m_flags;
  logic [3:0]          fr_cur;
  logic                step_plan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [19:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    sb.push_back(w);
  endtask

  task automatic set_fr(input logic [3:0] v);
    fr_cur = v;
    bus.fr = v;
  endtask

  // Advance one cycle; p is the expected phase (0 idle,1 RR,2 EX,3 WB), sok whether step lets it fire.
  task automatic tick(input int p, input logic sok);
    logic [19:0] e;
    logic        fire_wb;
    @(posedge clk);
    #1 bus.step = step_plan;
    @(negedge clk);
    fire_wb = (p == 3) && sok;
    chk("busy",        32'(bus.busy),        32'(p != 0));
    chk("rr_en",       32'(bus.rr_en),       32'((p == 1) && sok));
    chk("f_en",        32'(bus.f_en),        32'((p == 2) && sok));
    chk("wb_en",       32'(bus.wb_en),       32'(fire_wb));
    chk("instr_ready", 32'(bus.instr_ready), 32'((p == 0) || fire_wb));
    chk("op_count",    32'(bus.op_count),    32'(m_count));
    chk("last_flags",  32'(bus.last_flags),  32'(m_flags));
    if (fire_wb) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=wb_strobe expected=no_pending_op");
      end else begin
        e = sb.pop_front();
        chk("w_addr",    32'(bus.w_addr),    32'(e[14:10]));
        chk("r_addr_a",  32'(bus.r_addr_a),  32'(e[4:0]));
        chk("r_addr_b",  32'(bus.r_addr_b),  32'(e[9:5]));
        chk("alu_op",    32'(bus.alu_op),    32'(e[18:15]));
        chk("reg_write", 32'(bus.reg_write), 32'(e[19]));
      end
      m_count = m_count + TB_CNT_W'(1);
      m_flags = fr_cur;
    end else begin
      chk("reg_write_idle", 32'(bus.reg_write), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    sb.delete();
    m_count         = '0;
    m_flags         = '0;
    @(negedge clk);
    rst             = 1'b0;
  endtask

  // n operations back to back with instr_valid held high between them.
  task automatic burst(input int n);
    logic [19:0] w;
    w = 20'($urandom);
    present(w);
    for (int k = 0; k < n; k++) begin
      tick(1, 1'b1);
      if (k < n - 1) begin
        w = 20'($urandom);
        present(w);
      end else begin
        bus.instr_valid = 1'b0;
      end
      tick(2, 1'b1);
      set_fr(4'($urandom));
      tick(3, 1'b1);
    end
    tick(0, 1'b1);
  endtask

  initial begin
    int   p;
    logic sok;

    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.step        = 1'b1;
    bus.fr          = '0;
    fr_cur          = '0;
    step_plan       = 1'b1;
    m_count         = '0;
    m_flags         = '0;
    #2 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready",    32'(bus.instr_ready), 32'd1);
    chk("rst_busy",     32'(bus.busy),        32'd0);
    chk("rst_strobes",  32'({bus.rr_en, bus.f_en, bus.wb_en, bus.reg_write}), 32'd0);
    chk("rst_count",    32'(bus.op_count),    32'd0);
    chk("rst_addr",     32'({bus.r_addr_a, bus.r_addr_b, bus.w_addr, bus.alu_op}), 32'd0);
    chk("rst_flags",    32'(bus.last_flags),  32'd0);
    rst = 1'b0;

    // Single isolated op 0x90C41
    present(20'h90C41);
    set_fr(4'b0101);
    tick(1, 1'b1);
    bus.instr_valid = 1'b0;
    chk("t1_ra", 32'(bus.r_addr_a), 32'd1);
    chk("t1_rb", 32'(bus.r_addr_b), 32'd2);
    chk("t1_rd", 32'(bus.w_addr),   32'd3);
    chk("t1_op", 32'(bus.alu_op),   32'd2);
    tick(2, 1'b1);
    tick(3, 1'b1);
    tick(0, 1'b1);
    chk("t1_count", 32'(bus.op_count), 32'd1);
    chk("t1_hold_ra", 32'(bus.r_addr_a), 32'd1);
    chk("t1_hold_rd", 32'(bus.w_addr),   32'd3);
    tick(0, 1'b1);

    // Three back-to-back ops from a fresh count
    do_reset();
    burst(3);
    chk("t2_count", 32'(bus.op_count), 32'd3);

    // wr=0 op: no write, flags and count still update
    present({1'b0, 4'd5, 5'd7, 5'd9, 5'd31});
    set_fr(4'b1000);
    tick(1, 1'b1);
    bus.instr_valid = 1'b0;
    tick(2, 1'b1);
    tick(3, 1'b1);
    tick(0, 1'b1);
    chk("t3_flags", 32'(bus.last_flags), 32'h8);
    chk("t3_count", 32'(bus.op_count),   32'd4);

    // Asynchronous reset in the middle of EX
    present({1'b1, 4'd9, 5'd4, 5'd5, 5'd6});
    tick(1, 1'b1);
    bus.instr_valid = 1'b0;
    tick(2, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t4_f_en",  32'(bus.f_en),        32'd0);
    chk("t4_strb",  32'({bus.rr_en, bus.wb_en, bus.reg_write}), 32'd0);
    chk("t4_busy",  32'(bus.busy),        32'd0);
    chk("t4_ready", 32'(bus.instr_ready), 32'd1);
    chk("t4_count", 32'(bus.op_count),    32'd0);
    chk("t4_addr",  32'({bus.r_addr_a, bus.r_addr_b, bus.w_addr, bus.alu_op}), 32'd0);
    chk("t4_flags", 32'(bus.last_flags),  32'd0);
    sb.delete();
    m_count = '0;
    m_flags = '0;
    #1 rst = 1'b0;
    tick(0, 1'b1);

    // Sixteen ops wrap the 4-bit counter back to zero
    burst(16);
    chk("t5_wrap", 32'(bus.op_count), 32'd0);

    // Step pulse every fifth cycle
    do_reset();
    step_plan = 1'b0;
    bus.step  = 1'b0;
    present({1'b1, 4'd3, 5'd10, 5'd11, 5'd12});
    set_fr(4'b0011);
    p = 1;
    for (int c = 0; c < 20; c++) begin
      step_plan = ((c % 5) == 4);
`ifdef RRA_STEP_EN
      sok = step_plan;
`else
      sok = 1'b1;
`endif
      tick(p, sok);
      if (c == 0) bus.instr_valid = 1'b0;
      if ((p != 0) && sok) p = (p == 3) ? 0 : p + 1;
    end
    chk("t6_count", 32'(bus.op_count),   32'd1);
    chk("t6_flags", 32'(bus.last_flags), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rra_sequencer.md
# rra_sequencer

Micro-sequencer that issues register-read / ALU / write-back operations to the register-array datapath. It accepts one instruction word per operation through a valid/ready handshake and decodes it into register addresses and an ALU opcode. It then drives the datapath phase strobes `rr_en`, `f_en` and `wb_en` in order. It is the initiator for that datapath and replaces the hand-driven phase clocks and switches with single-clock enables.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  an instruction is presented on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction this cycle.
- `instr`  in  20  [19] wr, [18:15] alu_op, [14:10] rd, [9:5] rb, [4:0] ra.
- `step`  in  1  single-cycle advance pulse, already synchronized; used only with `RRA_STEP_EN`.
- `fr`  in  4  datapath flags {ZF,CF,OF,SF}, valid during the WB phase.
- `r_addr_a`, `r_addr_b`, `w_addr`  out  5 each  latched ra, rb, rd.
- `alu_op`  out  4  latched opcode.
- `rr_en`  out  1  operand-register load strobe.
- `f_en`  out  1  ALU result/flag capture strobe.
- `wb_en`  out  1  write-back strobe.
- `reg_write`  out  1  equals latched wr while `wb_en` is high, else 0.
- `last_flags`  out  4  `fr` captured on each WB strobe.
- `busy`  out  1  state is not IDLE.
- `op_count`  out  CNT_W  number of completed operations.

## Operation
- States: IDLE, RR, EX, WB.
- IDLE: `instr_ready`=1. On `instr_valid` high, latch all fields and go to RR.
- RR: `rr_en`=1 for one cycle, then go to EX.
- EX: `f_en`=1 for one cycle, then go to WB.
- WB:
  - `wb_en`=1 and `reg_write`=wr.
  - Capture `last_flags`<=`fr` and increment `op_count`.
  - `instr_ready`=1. If `instr_valid` is high, latch the new instruction and go to RR; otherwise go to IDLE.
- Outputs:
  - At most one strobe is high in any cycle.
  - Addresses and opcode hold their latched values until the next accept.
- `op_count` wraps from 2^CNT_W−1 to 0 without any flag.
- wr=0: the operation sequences normally but `reg_write` stays 0. `last_flags` and `op_count` still update.
- Back-to-back dependency (next ra/rb equals current rd): no hazard. WB commits at the edge that ends WB, and the next RR follows one cycle later. No forwarding logic.
- Instructions presented while `instr_ready`=0 are not consumed. The source must hold `instr` and `instr_valid` stable until accepted.
- Reset, including mid-operation:
  - Asynchronously forces IDLE; in-flight operation is dropped.
  - All strobes, `reg_write` and `busy` go to 0.
  - Addresses, `alu_op`, `last_flags` and `op_count` go to 0.
  - `instr_ready` goes to 1.

## Timing
- Accept edge at cycle 0; `rr_en` high in cycle 1, `f_en` in cycle 2, `wb_en` in cycle 3.
- Sustained throughput is one operation per 3 cycles (accept in WB). Isolated latency from accept to the end of write-back is 3 cycles.
- `instr_ready` is combinational from state only, never from `instr_valid`.
- `busy` is registered state decode: high from cycle 1 through the last WB.

## Configuration
- `RRA_STEP_EN` defined:
  - In RR, EX and WB, the state's strobe asserts, and the state advances, only in a cycle with `step`=1. The state holds otherwise.
  - IDLE accept is not gated by `step`.
  - In WB, `instr_ready` is high only when `step`=1.
  - This supports manual single-stepping on the board.
- `RRA_STEP_EN` undefined: `step` is ignored (treated as 1); timing is as above.

## Structure
- Shared package holds:
  - state encoding (2-bit enum);
  - instruction field positions and widths;
  - `ALU_OP_W`=4 and `REG_ADDR_W`=5;
  - flag bit indices ZF=3, CF=2, OF=1, SF=0.
- The flag bit order is shared with the datapath.
- One natural sub-module is `rra_instr_decode`: combinational field split of `instr` into wr, alu_op, rd, rb, ra. The FSM, latches and counter stay in the top.

## Test plan
- Reset then `instr`=0x90C41 (wr=1, op=2, rd=3, rb=2, ra=1) held valid one cycle:
  - `rr_en`, `f_en`, `wb_en` high in cycles 1, 2, 3;
  - `r_addr_a`=1, `r_addr_b`=2, `w_addr`=3, `alu_op`=2;
  - `reg_write`=1 only in cycle 3; `op_count`=1.
- Three instructions with `instr_valid` held high: strobes repeat every 3 cycles with no IDLE gap; `op_count`=3 after cycle 9.
- wr=0 instruction with `fr`=4'b1000 during WB: `reg_write` never high; `last_flags`=4'b1000; `op_count` increments.
- Assert `rst` asynchronously mid-EX: all strobes and `busy` drop immediately; `instr_ready`=1; `op_count`=0.
- `CNT_W`=4, 16 operations: `op_count` wraps to 0.
- `RRA_STEP_EN` with `step` pulsed every 5 cycles: exactly one strobe per pulse and the state holds between pulses. Without the macro, the same stimulus gives normal 3-cycle timing.
